// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Purpose  : Shared types and default constants for the register write
//            arbiter (FSM state encoding, default requester count and
//            data width).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

    // Two-state controller: IDLE arbitrates, WRITE presents the strobe.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin search. Scans req upward starting at
//            ptr, wrapping NREQ-1 -> 0, and reports the first set bit.
// Ports    : req   [NREQ-1:0] in  - request vector to search
//            ptr   [SELW-1:0] in  - starting index of the search
//            valid            out - at least one request found
//            idx   [SELW-1:0] out - index of the first request found
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SELW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            valid,
    output logic [SELW-1:0] idx
);

    always_comb begin
        int c;
        c     = 0;
        valid = 1'b0;
        idx   = '0;
        // Candidate positions ptr, ptr+1, ... taken modulo NREQ; the first
        // hit wins and later hits are ignored via the valid flag.
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx   = SELW'(c);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Shares one register-bank write port between NREQ requesters.
//            In IDLE a round-robin winner is chosen and grant / wr_en /
//            wr_sel / wr_data are registered on the same edge; the following
//            WRITE cycle presents the one-cycle strobe, then the FSM returns
//            to IDLE. At most one write every two cycles.
// Config   : REG_ARB_PRIO0_EN - when defined, requester 0 has absolute
//            priority and round-robin applies among requesters 1..NREQ-1.
// Ports    : clk                         in  - rising-edge clock
//            reset                       in  - asynchronous, active-low reset
//            req      [NREQ-1:0]         in  - per-requester write request
//            req_data [NREQ*Groupsize-1:0] in - packed per-requester data
//            grant    [NREQ-1:0]         out - one-hot acknowledge
//            wr_en                       out - one-cycle write strobe
//            wr_sel   [$clog2(NREQ)-1:0] out - target register (winner index)
//            wr_data  [Groupsize-1:0]    out - captured winner data
//            busy                        out - high while in WRITE
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int Groupsize = WIDTH_DEF,
    localparam int SELW     = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*Groupsize-1:0] req_data,
    output logic [NREQ-1:0]           grant,
    output logic                      wr_en,
    output logic [SELW-1:0]           wr_sel,
    output logic [Groupsize-1:0]      wr_data,
    output logic                      busy
);

    state_t                 state_q,   state_d;
    logic [SELW-1:0]        rr_ptr_q,  rr_ptr_d;
    logic [NREQ-1:0]        grant_q,   grant_d;
    logic                   wr_en_q,   wr_en_d;
    logic [SELW-1:0]        wr_sel_q,  wr_sel_d;
    logic [Groupsize-1:0]   wr_data_q, wr_data_d;

    logic [NREQ-1:0]        w_pick_req;
    logic                   w_rr_valid;
    logic [SELW-1:0]        w_rr_idx;
    logic                   w_win_valid;
    logic [SELW-1:0]        w_win_idx;

`ifdef REG_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation; masking it out of the search keeps
    // the round-robin fair among the remaining requesters.
    assign w_pick_req  = req & ~{{(NREQ-1){1'b0}}, 1'b1};
    assign w_win_valid = req[0] | w_rr_valid;
    assign w_win_idx   = req[0] ? '0 : w_rr_idx;
`else
    assign w_pick_req  = req;
    assign w_win_valid = w_rr_valid;
    assign w_win_idx   = w_rr_idx;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .SELW (SELW)
    ) u_rr_pick (
        .req   (w_pick_req),
        .ptr   (rr_ptr_q),
        .valid (w_rr_valid),
        .idx   (w_rr_idx)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = '0;
        wr_en_d   = 1'b0;
        wr_sel_d  = '0;
        wr_data_d = '0;
        case (state_q)
            IDLE: begin
                if (w_win_valid) begin
                    state_d   = WRITE;
                    grant_d   = NREQ'(1) << w_win_idx;
                    wr_en_d   = 1'b1;
                    wr_sel_d  = w_win_idx;
                    wr_data_d = req_data[w_win_idx*Groupsize +: Groupsize];
                    rr_ptr_d  = (w_win_idx == SELW'(NREQ - 1)) ? '0
                                                               : w_win_idx + SELW'(1);
                end
            end
            // Requests seen during WRITE are deliberately not evaluated;
            // the mandatory IDLE cycle lets the winner drop its request.
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign grant   = grant_q;
    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == WRITE);

endmodule : reg_write_arbiter
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Self-checking bench for reg_write_arbiter. A behavioural model
//            predicts every output each cycle; directed scenarios add literal
//            expectations for grant order, spacing and reset behaviour.
// Config   : REG_ARB_PRIO0_EN changes the expected grant order of the
//            priority scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic           wr_en;
    logic [1:0]     wr_sel;
    logic [W-1:0]   wr_data;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .NREQ      (N),
        .Groupsize (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The arbiter alternates: a cycle that shows a write is always followed
    // by a quiet cycle; otherwise the first requester at or after the
    // pointer (modulo N) wins and the pointer moves just past it.
    int           m_ptr   = 0;
    bit           m_busy  = 0;
    logic [N-1:0] m_grant = '0;
    logic         m_wr_en = 1'b0;
    int           m_sel   = 0;
    logic [W-1:0] m_data  = '0;
    int           m_win;

    task automatic model_clear();
        m_busy  = 0;
        m_grant = '0;
        m_wr_en = 1'b0;
        m_sel   = 0;
        m_data  = '0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
            m_ptr = 0;
        end else if (m_busy) begin
            model_clear();
        end else begin
            m_win = -1;
`ifdef REG_ARB_PRIO0_EN
            if (req[0]) m_win = 0;
`endif
            for (int k = 0; k < N; k++) begin
                if (m_win < 0 && req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
            end
            if (m_win >= 0) begin
                m_busy  = 1;
                m_grant = N'(1) << m_win;
                m_wr_en = 1'b1;
                m_sel   = m_win;
                m_data  = req_data[m_win*W +: W];
                m_ptr   = (m_win + 1) % N;
            end else begin
                model_clear();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("grant",   64'(grant),   64'(m_grant));
        check("wr_en",   64'(wr_en),   64'(m_wr_en));
        check("wr_sel",  64'(wr_sel),  64'(m_sel));
        check("wr_data", 64'(wr_data), 64'(m_data));
        check("busy",    64'(busy),    64'(m_busy));
    end

    // ---------------- grant recorder ----------------
    int got_idx[$];
    int got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_idx.push_back(int'(wr_sel));
            got_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        got_idx.delete();
        got_cyc.delete();
    endtask

    task automatic check_order(input string name, input int exp_q[$]);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_idx.size()) check(name, 64'(got_idx[i]), 64'(exp_q[i]));
            else                    check({name, "_missing"}, 64'(-1), 64'(exp_q[i]));
        end
    endtask

    task automatic check_spacing(input string name, input int n);
        for (int i = 1; i < n && i < got_cyc.size(); i++) begin
            check(name, 64'(got_cyc[i] - got_cyc[i-1]), 64'(2));
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reset asserted part-way through the WRITE cycle of pre_req's grant.
    task automatic reset_mid_write(input logic [N-1:0] pre_req, input logic [N-1:0] post_req,
                                   input logic [N-1:0] exp_grant, input string tag);
        req = pre_req;
        @(posedge clk);
        #1;
        check({tag, "_pre_wr_en"}, 64'(wr_en), 64'(1));
        #1;
        reset = 1'b0;
        #1;
        check({tag, "_rst_wr_en"}, 64'(wr_en), 64'(0));
        check({tag, "_rst_grant"}, 64'(grant), 64'(0));
        check({tag, "_rst_busy"},  64'(busy),  64'(0));
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        req   = post_req;
        @(negedge clk);
        check({tag, "_post_grant"}, 64'(grant), 64'(exp_grant));
        req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_q[$];
        int budget;

        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        check("reset_grant", 64'(grant), 64'(0));
        check("reset_wr_en", 64'(wr_en), 64'(0));
        check("reset_busy",  64'(busy),  64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Single request, data changes after capture must not leak through.
        req      = 4'b0100;
        req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        @(posedge clk);
        #1 req_data[23:16] = 8'h5A;
        @(negedge clk);
        check("single_grant",   64'(grant),   64'(4'b0100));
        check("single_wr_en",   64'(wr_en),   64'(1));
        check("single_wr_sel",  64'(wr_sel),  64'(2));
        check("single_wr_data", 64'(wr_data), 64'(8'hA5));
        check("single_busy",    64'(busy),    64'(1));
        check("model_pin",      64'(m_data),  64'(8'hA5));
        req = '0;
        @(negedge clk);
        check("single_after_grant", 64'(grant), 64'(0));
        check("single_after_wr_en", 64'(wr_en), 64'(0));
        check("single_after_busy",  64'(busy),  64'(0));

        // All four request; each drops after being granted.
        reset_pulse();
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        clear_log();
        req = 4'b1111;
        budget = 20;
        while (got_idx.size() < 4 && budget > 0) begin
            @(negedge clk);
            req = req & ~m_grant;
            budget--;
        end
        if (got_idx.size() < 4) check("all4_timeout", 64'(got_idx.size()), 64'(4));
        exp_q = '{0, 1, 2, 3};
        check_order("all4_order", exp_q);
        check_spacing("all4_spacing", 4);
        req = '0;
        @(negedge clk);

        // Fairness: 1 and 3 hold permanently.
        clear_log();
        req = 4'b1010;
        budget = 20;
        while (got_idx.size() < 4 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (got_idx.size() < 4) check("fair_timeout", 64'(got_idx.size()), 64'(4));
        exp_q = '{1, 3, 1, 3};
        check_order("fair_order", exp_q);
        check_spacing("fair_spacing", 4);
        req = '0;
        repeat (2) @(negedge clk);

        // Reset during WRITE: the pointer must restart at requester 0.
        reset_mid_write(4'b0010, 4'b1010, 4'b0010, "rst_rr");
        reset_mid_write(4'b0100, 4'b1000, 4'b1000, "rst_hi");

        // Requesters 0 and 1 hold; requester 0 drops after its third grant.
        reset_pulse();
        clear_log();
        req = 4'b0011;
        budget = 20;
        while (got_idx.size() < 4 && budget > 0) begin
            @(negedge clk);
            req = (got_idx.size() >= 3) ? 4'b0010 : 4'b0011;
            budget--;
        end
        if (got_idx.size() < 4) check("prio_timeout", 64'(got_idx.size()), 64'(4));
`ifdef REG_ARB_PRIO0_EN
        exp_q = '{0, 0, 0, 1};
`else
        exp_q = '{0, 1, 0, 1};
`endif
        check_order("prio_order", exp_q);
        req = '0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_reg_write_arbiter
`default_nettype wire
